// File: rtl/cpu_common_pkg.sv
// Shared definitions for the CPU data-memory responder.
//   - default byte base addresses for RAM and the MMIO timer window
//   - byte offsets of the four timer registers inside the 16-byte window
//   - decode result enum used by the responder
//   - byte-lane merge helper shared by the MMIO registers
package cpu_common_pkg;

  localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h0001_0000;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFF00_0000;

  localparam logic [3:0] MMIO_MTIME_LO    = 4'h0;
  localparam logic [3:0] MMIO_MTIME_HI    = 4'h4;
  localparam logic [3:0] MMIO_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MMIO_MTIMECMP_HI = 4'hC;

  typedef enum logic [1:0] {
    DMEM_SEL_RAM  = 2'd0,
    DMEM_SEL_MMIO = 2'd1,
    DMEM_SEL_NONE = 2'd2
  } dmem_sel_e;

  // Replace the bytes of old_word whose mask bit is set with new_word's bytes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port, read-first, byte-masked RAM with registered read data.
// Written in the template synthesis tools map onto block RAM.
// Ports:
//   clk_i  clock
//   en     read enable: q loads mem[addr] at the edge
//   we     per-byte write enables (independent of en)
//   addr   word index
//   wdata  write data, already lane-aligned
//   q      registered read data; holds while en is low
module dmem_bram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              q
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; a reset branch would prevent
  // block-RAM inference and turn the memory into thousands of flops.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments make the read sample the old word, which
    // is exactly the read-first behaviour when read and write collide.
    if (en) q <= mem[addr];
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory port.
// Decodes each access to on-chip RAM, the MMIO timer window, or nothing,
// returns read data one cycle after the read enable, and hosts the
// free-running 64-bit mtime / mtimecmp timer with its interrupt.
// Ports:
//   clk_i               clock
//   reset_i             asynchronous active-high reset
//   dmem_addr_i         byte address, bits [1:0] always zero
//   dmem_read_enable_i  read request this cycle
//   dmem_write_data_i   lane-shifted write data
//   dmem_write_mask_i   byte-lane write enables (0000 = no write)
//   dmem_read_data_o    read data, valid the cycle after a read, then held
//   irq_timer_o         registered mtime >= mtimecmp
//   bus_error_o         one-cycle pulse after an unmapped access
module dmem_responder
  import cpu_common_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_read_enable_i,
  input  logic [31:0] dmem_write_data_i,
  input  logic [3:0]  dmem_write_mask_i,
  output logic [31:0] dmem_read_data_o,
  output logic        irq_timer_o,
  output logic        bus_error_o
);

  localparam int AW = $clog2(DEPTH);

  dmem_sel_e   sel;
  dmem_sel_e   rsel_q;
  logic [3:0]  reg_off;
  logic [31:0] ram_q;
  logic [31:0] mmio_rdata;
  logic [31:0] mmio_rdata_q;
  logic [63:0] mtime_q;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_q;
  logic [63:0] mtimecmp_next;
  logic        irq_q;
  logic        bus_error_q;
  logic        access;

  // The initiator always drives word-aligned addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dmem_addr_i[1:0];

  assign reg_off = {dmem_addr_i[3:2], 2'b00};
  assign access  = dmem_read_enable_i || (dmem_write_mask_i != 4'b0000);

  // RAM_BASE is DEPTH*4 aligned, so an upper-bit match is the range check.
  always_comb begin
    // NOTE: assigning a default before any condition keeps always_comb free
    // of inferred latches when a new branch is added later.
    sel = DMEM_SEL_NONE;
    if (dmem_addr_i[31:AW+2] == RAM_BASE[31:AW+2]) begin
      sel = DMEM_SEL_RAM;
    end else if (dmem_addr_i[31:4] == MMIO_BASE[31:4]) begin
      sel = DMEM_SEL_MMIO;
    end
  end

  dmem_bram #(.DEPTH(DEPTH)) u_bram (
    .clk_i (clk_i),
    .en    (dmem_read_enable_i && (sel == DMEM_SEL_RAM)),
    .we    ((sel == DMEM_SEL_RAM) ? dmem_write_mask_i : 4'b0000),
    .addr  (dmem_addr_i[AW+1:2]),
    .wdata (dmem_write_data_i),
    .q     (ram_q)
  );

  // Reads see the register values before this cycle's update.
  always_comb begin
    mmio_rdata = 32'h0;
    case (reg_off)
      MMIO_MTIME_LO:    mmio_rdata = mtime_q[31:0];
      MMIO_MTIME_HI:    mmio_rdata = mtime_q[63:32];
      MMIO_MTIMECMP_LO: mmio_rdata = mtimecmp_q[31:0];
      MMIO_MTIMECMP_HI: mmio_rdata = mtimecmp_q[63:32];
      default:          mmio_rdata = 32'h0;
    endcase
  end

  // A write to either mtime half replaces the increment for that cycle;
  // bytes left unwritten keep their pre-increment value.
  always_comb begin
    mtime_next    = mtime_q + 64'd1;
    mtimecmp_next = mtimecmp_q;
    if (sel == DMEM_SEL_MMIO && dmem_write_mask_i != 4'b0000) begin
      case (reg_off)
        MMIO_MTIME_LO: mtime_next = {mtime_q[63:32],
          merge_bytes(mtime_q[31:0], dmem_write_data_i, dmem_write_mask_i)};
        MMIO_MTIME_HI: mtime_next = {
          merge_bytes(mtime_q[63:32], dmem_write_data_i, dmem_write_mask_i),
          mtime_q[31:0]};
        MMIO_MTIMECMP_LO: mtimecmp_next = {mtimecmp_q[63:32],
          merge_bytes(mtimecmp_q[31:0], dmem_write_data_i, dmem_write_mask_i)};
        MMIO_MTIMECMP_HI: mtimecmp_next = {
          merge_bytes(mtimecmp_q[63:32], dmem_write_data_i, dmem_write_mask_i),
          mtimecmp_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mtime_q      <= 64'h0;
      mtimecmp_q   <= '1;
      irq_q        <= 1'b0;
      bus_error_q  <= 1'b0;
      rsel_q       <= DMEM_SEL_NONE;
      mmio_rdata_q <= 32'h0;
    end else begin
      mtime_q     <= mtime_next;
      mtimecmp_q  <= mtimecmp_next;
      irq_q       <= (mtime_next >= mtimecmp_next);
      bus_error_q <= (sel == DMEM_SEL_NONE) && access;
      if (dmem_read_enable_i) begin
        rsel_q <= sel;
        if (sel == DMEM_SEL_MMIO) mmio_rdata_q <= mmio_rdata;
      end
    end
  end

  // rsel_q remembers the source of the last read. RAM data holds inside the
  // BRAM until its next read, and DMEM_SEL_NONE (also the reset value) gives 0.
  always_comb begin
    dmem_read_data_o = 32'h0;
    case (rsel_q)
      DMEM_SEL_RAM:  dmem_read_data_o = ram_q;
      DMEM_SEL_MMIO: dmem_read_data_o = mmio_rdata_q;
      default:       dmem_read_data_o = 32'h0;
    endcase
  end

  assign irq_timer_o = irq_q;
  assign bus_error_o = bus_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_dmem_responder;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] RAM_BASE  = 32'h0001_0000;
  localparam logic [31:0] MMIO_BASE = 32'hFF00_0000;
  localparam logic [31:0] RAM_END   = RAM_BASE + DEPTH * 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] dmem_addr_i;
  logic        dmem_read_enable_i;
  logic [31:0] dmem_write_data_i;
  logic [3:0]  dmem_write_mask_i;
  logic [31:0] dmem_read_data_o;
  logic        irq_timer_o;
  logic        bus_error_o;

  dmem_responder #(.DEPTH(DEPTH), .RAM_BASE(RAM_BASE), .MMIO_BASE(MMIO_BASE)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .dmem_addr_i        (dmem_addr_i),
    .dmem_read_enable_i (dmem_read_enable_i),
    .dmem_write_data_i  (dmem_write_data_i),
    .dmem_write_mask_i  (dmem_write_mask_i),
    .dmem_read_data_o   (dmem_read_data_o),
    .irq_timer_o        (irq_timer_o),
    .bus_error_o        (bus_error_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_ram [int unsigned];
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_rdata;
  logic        m_irq, m_berr;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  m);
    logic [31:0] keep;
    keep = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~keep) | (new_w & keep);
  endfunction

  task automatic model_reset();
    m_time  = 64'd0;
    m_cmp   = {64{1'b1}};
    m_rdata = 32'd0;
    m_irq   = 1'b0;
    m_berr  = 1'b0;
  endtask

  task automatic model_cycle(input logic [31:0] a, input logic re,
                             input logic [31:0] wd, input logic [3:0] m);
    logic [63:0] t0, c0;
    bit is_ram, is_mmio, timer_written;
    int unsigned idx;
    t0 = m_time;
    c0 = m_cmp;
    timer_written = 0;
    is_ram  = ({32'd0, a} >= {32'd0, RAM_BASE}) && ({32'd0, a} < {32'd0, RAM_BASE} + 64'(DEPTH * 4));
    is_mmio = (a >> 4) == (MMIO_BASE >> 4);
    idx = (a - RAM_BASE) >> 2;
    if (re) begin
      if (is_ram) m_rdata = model_ram[idx];
      else if (is_mmio) begin
        case (a[3:0])
          4'h0:    m_rdata = t0[31:0];
          4'h4:    m_rdata = t0[63:32];
          4'h8:    m_rdata = c0[31:0];
          default: m_rdata = c0[63:32];
        endcase
      end else m_rdata = 32'd0;
    end
    m_berr = !is_ram && !is_mmio && (re || m != 4'd0);
    if (m != 4'd0) begin
      if (is_ram) model_ram[idx] = lane_merge(model_ram[idx], wd, m);
      else if (is_mmio) begin
        case (a[3:0])
          4'h0: begin m_time[31:0]  = lane_merge(t0[31:0],  wd, m); timer_written = 1; end
          4'h4: begin m_time[63:32] = lane_merge(t0[63:32], wd, m); timer_written = 1; end
          4'h8:    m_cmp[31:0]  = lane_merge(c0[31:0],  wd, m);
          default: m_cmp[63:32] = lane_merge(c0[63:32], wd, m);
        endcase
      end
    end
    if (!timer_written) m_time = t0 + 64'd1;
    m_irq = (m_time >= m_cmp);
  endtask

  // One bus cycle: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input string tag, input logic [31:0] a, input logic re,
                      input logic [31:0] wd, input logic [3:0] m);
    dmem_addr_i        = a;
    dmem_read_enable_i = re;
    dmem_write_data_i  = wd;
    dmem_write_mask_i  = m;
    @(posedge clk_i);
    #1;
    model_cycle(a, re, wd, m);
    check({tag, "/rdata"}, dmem_read_data_o, m_rdata);
    check({tag, "/irq"},   irq_timer_o,      m_irq);
    check({tag, "/berr"},  bus_error_o,      m_berr);
    @(negedge clk_i);
  endtask

  task automatic idle(input string tag);
    step(tag, RAM_BASE, 1'b0, 32'd0, 4'd0);
  endtask

  int unsigned ram_idx [8] = '{0, 1, 2, 3, 4, 100, DEPTH - 2, DEPTH - 1};
  logic [31:0] unmapped [6] = '{RAM_BASE - 4, RAM_END, 32'h8000_0000,
                                MMIO_BASE + 16, MMIO_BASE - 4, 32'h0};

  initial begin
    reset_i            = 1'b1;
    dmem_addr_i        = 32'd0;
    dmem_read_enable_i = 1'b0;
    dmem_write_data_i  = 32'd0;
    dmem_write_mask_i  = 4'd0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("reset/rdata", dmem_read_data_o, 32'd0);
    check("reset/irq",   irq_timer_o,      1'b0);
    check("reset/berr",  bus_error_o,      1'b0);
    reset_i = 1'b0;

    // Timer interrupt with mtimecmp = 20, then raised above mtime.
    step("t5_cmphi", MMIO_BASE + 12, 1'b0, 32'd0,  4'hF);
    step("t5_cmplo", MMIO_BASE + 8,  1'b0, 32'd20, 4'hF);
    for (int i = 0; i < 40 && m_time < 64'd19; i++) idle("t5_wait");
    check("t5_irq_low", irq_timer_o, 1'b0);
    idle("t5_reach");
    check("t5_mtime_is_20", m_time, 64'd20);
    check("t5_irq_rise", irq_timer_o, 1'b1);
    step("t5_raise", MMIO_BASE + 12, 1'b0, 32'd1, 4'hF);
    check("t5_irq_fall", irq_timer_o, 1'b0);

    // Give every RAM word used later a known value.
    foreach (ram_idx[i]) step("init", RAM_BASE + 4 * ram_idx[i], 1'b0, $urandom, 4'hF);

    // Full-word write then read.
    step("t1_wr", RAM_BASE + 8, 1'b0, 32'hDEAD_BEEF, 4'hF);
    step("t1_rd", RAM_BASE + 8, 1'b1, 32'd0, 4'd0);
    check("t1_data", dmem_read_data_o, 32'hDEAD_BEEF);
    idle("t1_hold");
    check("t1_hold_data", dmem_read_data_o, 32'hDEAD_BEEF);

    // Partial masks.
    step("t2_w0", RAM_BASE + 12, 1'b0, 32'h1122_3344, 4'hF);
    step("t2_w1", RAM_BASE + 12, 1'b0, 32'hAA00_0000, 4'h8);
    step("t2_w2", RAM_BASE + 12, 1'b0, 32'h0000_BBBB, 4'h3);
    step("t2_rd", RAM_BASE + 12, 1'b1, 32'd0, 4'd0);
    check("t2_data", dmem_read_data_o, 32'hAA22_BBBB);

    // Read-first collision.
    step("t3_w0",  RAM_BASE + 16, 1'b0, 32'h1, 4'hF);
    step("t3_rw",  RAM_BASE + 16, 1'b1, 32'h5, 4'hF);
    check("t3_old", dmem_read_data_o, 32'h1);
    step("t3_rd",  RAM_BASE + 16, 1'b1, 32'h0, 4'h0);
    check("t3_new", dmem_read_data_o, 32'h5);

    // mtime carry from lo into hi.
    step("t4_lo", MMIO_BASE + 0, 1'b0, 32'hFFFF_FFFF, 4'hF);
    step("t4_hi", MMIO_BASE + 4, 1'b0, 32'h0,         4'hF);
    step("t4_rlo", MMIO_BASE + 0, 1'b1, 32'h0, 4'h0);
    check("t4_lo_val", dmem_read_data_o, 32'hFFFF_FFFF);
    step("t4_rhi", MMIO_BASE + 4, 1'b1, 32'h0, 4'h0);
    check("t4_hi_val", dmem_read_data_o, 32'h1);

    // 64-bit wrap.
    step("wrap_lo", MMIO_BASE + 0, 1'b0, 32'hFFFF_FFFF, 4'hF);
    step("wrap_hi", MMIO_BASE + 4, 1'b0, 32'hFFFF_FFFF, 4'hF);
    step("wrap_rhi", MMIO_BASE + 4, 1'b1, 32'h0, 4'h0);
    check("wrap_hi_val", dmem_read_data_o, 32'hFFFF_FFFF);
    step("wrap_rlo", MMIO_BASE + 0, 1'b1, 32'h0, 4'h0);
    check("wrap_lo_val", dmem_read_data_o, 32'h0);

    // Unmapped access and RAM boundary.
    step("t6_rd", 32'h8000_0000, 1'b1, 32'h0, 4'h0);
    check("t6_rdata", dmem_read_data_o, 32'h0);
    check("t6_berr",  bus_error_o,      1'b1);
    idle("t6_after");
    check("t6_berr_drop", bus_error_o, 1'b0);
    step("bnd_out", RAM_END, 1'b1, 32'h0, 4'h0);
    check("bnd_out_berr", bus_error_o, 1'b1);
    step("bnd_in", RAM_END - 4, 1'b1, 32'h0, 4'h0);
    check("bnd_in_berr", bus_error_o, 1'b0);
    step("unmapped_wr", RAM_BASE - 4, 1'b0, 32'h1234_5678, 4'hF);
    check("unmapped_wr_berr", bus_error_o, 1'b1);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [31:0] a;
      logic [3:0]  m;
      kind = $urandom_range(0, 9);
      if (kind < 6)      a = RAM_BASE + 4 * ram_idx[$urandom_range(0, 7)];
      else if (kind < 8) a = MMIO_BASE + 4 * $urandom_range(0, 3);
      else               a = unmapped[$urandom_range(0, 5)];
      m = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step("rand", a, 1'($urandom_range(0, 1)), $urandom, m);
    end

    // Reset in the middle of activity.
    step("pre_cmphi", MMIO_BASE + 12, 1'b0, 32'h0, 4'hF);
    step("pre_cmplo", MMIO_BASE + 8,  1'b0, 32'h0, 4'hF);
    step("pre_wr", RAM_BASE + 8, 1'b0, 32'hDEAD_BEEF, 4'hF);
    step("pre_rd", RAM_BASE + 8, 1'b1, 32'h0, 4'h0);
    check("pre_reset_irq", irq_timer_o, 1'b1);
    dmem_addr_i        = MMIO_BASE;
    dmem_read_enable_i = 1'b0;
    dmem_write_data_i  = 32'h0000_1234;
    dmem_write_mask_i  = 4'hF;
    reset_i            = 1'b1;
    #1;
    check("rst_mid/rdata", dmem_read_data_o, 32'h0);
    check("rst_mid/irq",   irq_timer_o,      1'b0);
    check("rst_mid/berr",  bus_error_o,      1'b0);
    @(negedge clk_i);
    dmem_write_mask_i = 4'h0;
    reset_i = 1'b0;
    model_reset();
    step("rst_rlo", MMIO_BASE + 0, 1'b1, 32'h0, 4'h0);
    check("rst_mtime_lo", dmem_read_data_o, 32'h0);
    step("rst_rhi", MMIO_BASE + 4, 1'b1, 32'h0, 4'h0);
    check("rst_mtime_hi", dmem_read_data_o, 32'h0);
    step("rst_rlo2", MMIO_BASE + 0, 1'b1, 32'h0, 4'h0);
    check("rst_mtime_lo2", dmem_read_data_o, 32'h2);
    step("rst_ram_kept", RAM_BASE + 8, 1'b1, 32'h0, 4'h0);
    check("rst_ram_kept_val", dmem_read_data_o, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
